// File: rtl/dm_store_buffer_if.sv
// dm_store_buffer_if: store, load-hazard and DM write-port signals of the store buffer (fwd ports with DM_SB_FWD_EN)
interface dm_store_buffer_if #(parameter int PTRW = 2);
  logic            st_valid;
  logic [31:0]     st_addr;
  logic [31:0]     st_data;
  logic [1:0]      st_size;
  logic            st_ready;
  logic            misalign;
  logic            ld_valid;
  logic [31:0]     ld_addr;
  logic            ld_stall;
  logic            dm_busy;
  logic            dm_we;
  logic [31:0]     dm_addr;
  logic [31:0]     dm_wd;
  logic [3:0]      dm_be;
  logic [PTRW:0]   count;
`ifdef DM_SB_FWD_EN
  logic            fwd_hit;
  logic [31:0]     fwd_data;
`endif
  modport master (
`ifdef DM_SB_FWD_EN
    input  fwd_hit, fwd_data,
`endif
    output st_valid, st_addr, st_data, st_size, ld_valid, ld_addr, dm_busy,
    input  st_ready, misalign, ld_stall, dm_we, dm_addr, dm_wd, dm_be, count
  );
  modport slave (
`ifdef DM_SB_FWD_EN
    output fwd_hit, fwd_data,
`endif
    input  st_valid, st_addr, st_data, st_size, ld_valid, ld_addr, dm_busy,
    output st_ready, misalign, ld_stall, dm_we, dm_addr, dm_wd, dm_be, count
  );
endinterface

// File: rtl/dm_store_buffer.sv
// dm_store_buffer: FIFO store buffer feeding the DM write port with load-hazard stall; DM_SB_FWD_EN adds full-word forwarding
module dm_store_buffer #(
  parameter int DEPTH = 4,
  parameter int PTRW  = 2
) (
  input logic           clk,
  input logic           clr,
  dm_store_buffer_if.slave sb
);
  logic [31:0]      addr_q [DEPTH];
  logic [31:0]      data_q [DEPTH];
  logic [3:0]       be_q   [DEPTH];
  logic [DEPTH-1:0] vld_q;
  logic [PTRW-1:0]  head, tail, idx;
  logic [PTRW:0]    cnt;
  logic             mis_q, err, enq, deq, found;
  logic [3:0]       be_n;
`ifdef DM_SB_FWD_EN
  logic [3:0]       y_be;
  logic [31:0]      y_data;
  logic             fwd;
`endif
  always_comb begin
    be_n = sb.st_size == 2'b00 ? 4'b0001 << sb.st_addr[1:0] :
           sb.st_size == 2'b01 ? (sb.st_addr[1] ? 4'b1100 : 4'b0011) : 4'b1111;
    err  = (sb.st_size == 2'b11) | (sb.st_size == 2'b01 & sb.st_addr[0]) |
           (sb.st_size == 2'b10 & sb.st_addr[1:0] != 2'b00);
    enq  = sb.st_valid & sb.st_ready & ~err;
    deq  = sb.dm_we;
  end
  assign sb.st_ready = cnt != (PTRW+1)'(DEPTH);
  assign sb.dm_we    = (cnt != '0) & ~sb.dm_busy;
  assign sb.dm_addr  = addr_q[head];
  assign sb.dm_wd    = data_q[head];
  assign sb.dm_be    = be_q[head];
  assign sb.count    = cnt;
  assign sb.misalign = mis_q;
  always_ff @(posedge clk) begin
    if (enq) begin
      addr_q[tail] <= sb.st_addr;
      data_q[tail] <= sb.st_data;
      be_q[tail]   <= be_n;
    end
  end
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      vld_q <= '0;
      head  <= '0;
      tail  <= '0;
      cnt   <= '0;
      mis_q <= 1'b0;
    end else begin
      if (deq) vld_q[head] <= 1'b0;
      if (enq) vld_q[tail] <= 1'b1;
      head  <= head + PTRW'(deq);
      tail  <= tail + PTRW'(enq);
      cnt   <= cnt + (PTRW+1)'(enq) - (PTRW+1)'(deq);
      mis_q <= sb.st_valid & err;
    end
  end
  // scan youngest-first so the first hit is the most recent store to that word
  always_comb begin
    found = 1'b0;
    idx   = '0;
`ifdef DM_SB_FWD_EN
    y_be   = '0;
    y_data = '0;
`endif
    for (int i = 1; i <= DEPTH; i++) begin
      idx = tail - PTRW'(i);
      if (!found && vld_q[idx] && addr_q[idx][31:2] == sb.ld_addr[31:2]) begin
        found = 1'b1;
`ifdef DM_SB_FWD_EN
        y_be   = be_q[idx];
        y_data = data_q[idx];
`endif
      end
    end
`ifdef DM_SB_FWD_EN
    fwd         = found & (y_be == 4'b1111);
    sb.fwd_hit  = sb.ld_valid & fwd;
    sb.fwd_data = y_data;
    sb.ld_stall = sb.ld_valid & found & ~fwd;
`else
    sb.ld_stall = sb.ld_valid & found;
`endif
  end
endmodule

// File: tb/tb_dm_store_buffer.sv
// tb_dm_store_buffer: directed stimulus with a DM-write scoreboard checked by a decoupled monitor
module tb_dm_store_buffer;
  logic clk = 1'b0;
  logic clr = 1'b1;
  int tests = 0;
  int fails = 0;
  typedef struct { logic [31:0] a; logic [31:0] d; logic [3:0] be; } wr_t;
  wr_t exp_q[$];
  dm_store_buffer_if #(.PTRW(2)) sb();
  dm_store_buffer #(.DEPTH(4), .PTRW(2)) dut (.clk(clk), .clr(clr), .sb(sb.slave));
  always #5 clk = ~clk;
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask
  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask
  task automatic store(input logic [31:0] a, input logic [31:0] d, input logic [1:0] sz,
                       input logic push, input logic [3:0] be);
    sb.st_valid = 1'b1;
    sb.st_addr  = a;
    sb.st_data  = d;
    sb.st_size  = sz;
    if (push) exp_q.push_back('{a: a, d: d, be: be});
    @(posedge clk);
    #1;
    sb.st_valid = 1'b0;
  endtask
  initial begin
    wr_t w;
    forever begin
      @(negedge clk);
      if (sb.dm_we === 1'b1) begin
        tests++;
        if (exp_q.size() == 0) begin
          fails++;
          $display("FAIL dm_write: unexpected write addr=%h wd=%h be=%b", sb.dm_addr, sb.dm_wd, sb.dm_be);
        end else begin
          w = exp_q.pop_front();
          if ({sb.dm_addr, sb.dm_wd, sb.dm_be} !== {w.a, w.d, w.be}) begin
            fails++;
            $display("FAIL dm_write: got addr=%h wd=%h be=%b expected addr=%h wd=%h be=%b",
                     sb.dm_addr, sb.dm_wd, sb.dm_be, w.a, w.d, w.be);
          end
        end
      end
    end
  end
  initial begin
    sb.st_valid = 1'b0;
    sb.st_addr  = '0;
    sb.st_data  = '0;
    sb.st_size  = '0;
    sb.ld_valid = 1'b0;
    sb.ld_addr  = '0;
    sb.dm_busy  = 1'b0;
    #2;
    check("reset_count", 32'(sb.count), 0);
    check("reset_dm_we", 32'(sb.dm_we), 0);
    check("reset_st_ready", 32'(sb.st_ready), 1);
    check("reset_misalign", 32'(sb.misalign), 0);
    @(posedge clk);
    #1;
    clr = 1'b0;
    store(32'h10, 32'hDEADBEEF, 2'b10, 1'b1, 4'b1111);
    check("t1_dm_we", 32'(sb.dm_we), 1);
    check("t1_count_busy", 32'(sb.count), 1);
    tick(1);
    check("t1_count_done", 32'(sb.count), 0);
    check("t1_dm_we_done", 32'(sb.dm_we), 0);
    store(32'h13, 32'h000000AB, 2'b00, 1'b1, 4'b1000);
    store(32'h22, 32'h00001234, 2'b01, 1'b1, 4'b1100);
    check("t2_count_overlap", 32'(sb.count), 1);
    tick(1);
    check("t2_count_done", 32'(sb.count), 0);
    sb.dm_busy = 1'b1;
    for (int i = 0; i < 4; i++)
      store(32'h100 + 32'(4 * i), 32'hA0 + 32'(i), 2'b10, 1'b1, 4'b1111);
    check("t3_count_full", 32'(sb.count), 4);
    check("t3_st_ready_full", 32'(sb.st_ready), 0);
    check("t3_dm_we_busy", 32'(sb.dm_we), 0);
    store(32'h200, 32'hBAD0BAD0, 2'b10, 1'b0, 4'b1111);
    check("t3_count_rejected", 32'(sb.count), 4);
    sb.dm_busy = 1'b0;
    tick(1);
    check("t3_count_drain1", 32'(sb.count), 3);
    tick(3);
    check("t3_count_drained", 32'(sb.count), 0);
    store(32'h21, 32'h1111, 2'b01, 1'b0, 4'b0000);
    check("t4_misalign_half", 32'(sb.misalign), 1);
    check("t4_count_half", 32'(sb.count), 0);
    tick(1);
    check("t4_misalign_clear1", 32'(sb.misalign), 0);
    store(32'h22, 32'h2222, 2'b10, 1'b0, 4'b0000);
    check("t4_misalign_word", 32'(sb.misalign), 1);
    tick(1);
    check("t4_misalign_clear2", 32'(sb.misalign), 0);
    store(32'h30, 32'h3333, 2'b11, 1'b0, 4'b0000);
    check("t4_misalign_size11", 32'(sb.misalign), 1);
    check("t4_count_end", 32'(sb.count), 0);
    tick(1);
    sb.dm_busy = 1'b1;
    store(32'h40, 32'h55, 2'b00, 1'b1, 4'b0001);
    sb.ld_valid = 1'b1;
    sb.ld_addr  = 32'h43;
    #1 check("t5_stall_match", 32'(sb.ld_stall), 1);
    sb.ld_addr = 32'h44;
    #1 check("t5_stall_other_word", 32'(sb.ld_stall), 0);
    sb.ld_valid = 1'b0;
    sb.ld_addr  = 32'h40;
    #1 check("t5_stall_no_valid", 32'(sb.ld_stall), 0);
    store(32'h40, 32'hCAFEF00D, 2'b10, 1'b1, 4'b1111);
    sb.ld_valid = 1'b1;
    sb.ld_addr  = 32'h40;
    #1;
`ifdef DM_SB_FWD_EN
    check("t5_fwd_hit", 32'(sb.fwd_hit), 1);
    check("t5_fwd_data", sb.fwd_data, 32'hCAFEF00D);
    check("t5_fwd_no_stall", 32'(sb.ld_stall), 0);
`else
    check("t5_stall_word", 32'(sb.ld_stall), 1);
`endif
    sb.ld_valid = 1'b0;
    sb.dm_busy  = 1'b0;
    tick(2);
    check("t5_count_drained", 32'(sb.count), 0);
    sb.dm_busy = 1'b1;
    for (int i = 0; i < 3; i++)
      store(32'h300 + 32'(4 * i), 32'h77 + 32'(i), 2'b10, 1'b0, 4'b1111);
    check("t6_count_queued", 32'(sb.count), 3);
    sb.dm_busy = 1'b0;
    #1 check("t6_dm_we_before", 32'(sb.dm_we), 1);
    #1 clr = 1'b1;
    #1;
    check("t6_dm_we_async", 32'(sb.dm_we), 0);
    check("t6_count_async", 32'(sb.count), 0);
    check("t6_st_ready_async", 32'(sb.st_ready), 1);
    tick(1);
    clr = 1'b0;
    tick(3);
    check("t6_count_after", 32'(sb.count), 0);
    check("scoreboard_empty", 32'(exp_q.size()), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/dm_store_buffer.md
Name: dm_store_buffer

Overview:
- FIFO store buffer between the MEM-stage store path and the data memory (DM) write port.
- Accepts stores of byte/half/word size, generates DM byte enables (be), checks alignment, queues entries, and drains one per cycle into DM when the port is free.
- Stalls loads whose word address matches a pending store, so DM reads never return stale data.

Parameters:
- DEPTH, 4, number of queued store entries (power of two, >=2)
- PTRW, 2, pointer width = log2(DEPTH)

Ports:
- clk  input  1  clock, all state updates on rising edge
- clr  input  1  asynchronous active-high reset
- st_valid  input  1  MEM stage presents a store this cycle
- st_addr  input  32  store byte address
- st_data  input  32  store data, low-justified (byte in [7:0], half in [15:0])
- st_size  input  2  00 byte, 01 half, 10 word, 11 illegal
- st_ready  output  1  buffer can accept a store this cycle
- misalign  output  1  registered one-cycle pulse: the last offered store was dropped
- ld_valid  input  1  MEM stage issues a DM load this cycle
- ld_addr  input  32  load byte address
- ld_stall  output  1  load word matches a pending store; pipeline must hold
- dm_busy  input  1  DM port used by a load this cycle; no drain allowed
- dm_we  output  1  DM write enable
- dm_addr  output  32  DM address, from the head entry
- dm_wd  output  32  DM write data, head entry data, low-justified
- dm_be  output  4  DM byte enable, head entry
- count  output  PTRW+1  number of valid entries

Behaviour:
- Reset (async, clr=1): head, tail and count = 0, all entry valid bits = 0, misalign = 0. dm_we = 0 immediately, with no edge required. A reset mid-drain discards all entries.
- st_ready = (count != DEPTH). This is combinational and ignores a same-cycle pop, so a full buffer never accepts a store, even while draining.
- be generation: byte gives 4'b0001 << addr[1:0]; half gives addr[1] ? 4'b1100 : 4'b0011; word gives 4'b1111.
- Entry contents: {addr, data, be}. Data is stored unmodified, because DM performs its own lane placement from be.
- Alignment check:
  - A half store with addr[0]=1 is an error.
  - A word store with addr[1:0]!=0 is an error.
  - st_size=11 is always an error.
  - On error: the store is not enqueued and misalign=1 for exactly the next cycle. The misalign pulse is independent of st_ready.
- Enqueue: at the edge where st_valid & st_ready & no alignment error; write the tail entry, then tail += 1 (wraps mod DEPTH).
- Drain: dm_we = (count != 0) & ~dm_busy, combinational. dm_addr, dm_wd and dm_be always reflect the head entry. At the edge where dm_we=1, head += 1 (wraps mod DEPTH).
- Latency: a store accepted at edge k drives dm_we in the cycle after edge k, provided the buffer was empty and dm_busy=0.
- Count update: +1 on enqueue only, -1 on drain only, unchanged when both happen in the same cycle.
- Load hazard: ld_stall = ld_valid & any valid entry with entry.addr[31:2] == ld_addr[31:2]. This is combinational and ignores be overlap (conservative).
- While ld_stall=1, the buffer continues draining whenever dm_busy=0. The upstream stage must deassert dm_busy while stalled.
- Strict FIFO order; DM write order equals store program order.

Optional Feature:
- Macro: DM_SB_FWD_EN.
- Defined:
  - Adds outputs fwd_hit (1) and fwd_data (32).
  - If the youngest matching entry has be=1111, then fwd_hit=1, fwd_data = that entry's data, and ld_stall=0.
  - Otherwise behaviour is as without forwarding.
  - The youngest match is chosen by scanning from tail-1 back to head.
- Undefined: the ports are absent and any match stalls.

Test Plan:
- Reset, then word store addr=0x10 data=0xDEADBEEF with dm_busy=0 -> next cycle dm_we=1, dm_addr=0x10, dm_be=1111, dm_wd=0xDEADBEEF; count returns to 0 after the edge.
- Byte store to 0x13 data=0xAB, then half store to 0x22 data=0x1234 -> dm_be=1000 then 1100, with dm_wd low bits 0xAB and 0x1234.
- Hold dm_busy=1 and issue 5 word stores -> count=4, st_ready=0 on the fifth store, which is not enqueued. Then release dm_busy -> four writes in FIFO order, one per cycle.
- Half store to 0x21 and word store to 0x22 -> neither is enqueued, misalign pulses for one cycle each, count stays 0.
- Pending byte store to 0x40 with dm_busy=1, and ld_valid with ld_addr=0x43 -> ld_stall=1; with ld_addr=0x44 -> ld_stall=0. With DM_SB_FWD_EN and a pending word store to 0x40, ld_addr=0x40 -> fwd_hit=1 and ld_stall=0.
- Three entries queued, assert clr asynchronously between edges -> dm_we and count drop to 0 at once, and no DM write occurs.
